// File: rtl/tc_digital_io_bank.sv
// rtl/tc_digital_io_bank.sv - digital IO bank with retention-held pad controls, debounced inputs and edge interrupts
module tc_digital_io_bank #(
  parameter int NumPads      = 8,
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 3,
  parameter int DrvWidth     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rte_i,
  input  logic [NumPads-1:0]            data_i,
  input  logic [NumPads-1:0]            oe_ni,
  input  logic [NumPads*DrvWidth-1:0]   drv_i,
  input  logic [NumPads-1:0]            pullup_en_i,
  input  logic [NumPads-1:0]            pulldown_en_i,
  output logic [NumPads-1:0]            pad_data_o,
  output logic [NumPads-1:0]            pad_oe_no,
  output logic [NumPads*DrvWidth-1:0]   pad_drv_o,
  output logic [NumPads-1:0]            pad_pu_o,
  output logic [NumPads-1:0]            pad_pd_o,
  input  logic [NumPads-1:0]            pad_data_i,
  output logic [NumPads-1:0]            data_o,
  input  logic [NumPads-1:0]            rise_en_i,
  input  logic [NumPads-1:0]            fall_en_i,
  input  logic [NumPads-1:0]            irq_clr_i,
  output logic [NumPads-1:0]            irq_status_o,
  output logic                          irq_o,
  output logic [NumPads-1:0]            pull_conflict_o
);

  logic [NumPads-1:0] sync_q [SyncStages];
  logic [NumPads-1:0] sync;
  logic [NumPads-1:0] filt;
  logic [NumPads-1:0] filt_d;
  logic [NumPads-1:0] rise_evt;
  logic [NumPads-1:0] fall_evt;

  // Pad-side controls freeze while in retention; a conflicting pull pair drives neither pull.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pad_data_o      <= '0;
      pad_oe_no       <= '1;
      pad_drv_o       <= '0;
      pad_pu_o        <= '0;
      pad_pd_o        <= '0;
      pull_conflict_o <= '0;
    end else if (!rte_i) begin
      pad_data_o      <= data_i;
      pad_oe_no       <= oe_ni;
      pad_drv_o       <= drv_i;
      pad_pu_o        <= pullup_en_i & ~pulldown_en_i;
      pad_pd_o        <= pulldown_en_i & ~pullup_en_i;
      pull_conflict_o <= pullup_en_i & pulldown_en_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_data_i;
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SyncStages-1];

  generate
    if (FilterCycles > 0) begin : g_filt
      localparam int CntW = $clog2(FilterCycles + 1);
      localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

      logic [CntW-1:0]    cnt_q [NumPads];
      logic [NumPads-1:0] filt_q;

      // A mismatch must survive FilterCycles consecutive edges; any match restarts the count.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          filt_q <= '0;
          for (int p = 0; p < NumPads; p++) cnt_q[p] <= '0;
        end else begin
          for (int p = 0; p < NumPads; p++) begin
            if (sync[p] == filt_q[p]) begin
              cnt_q[p] <= '0;
            end else if (cnt_q[p] == CntLast) begin
              filt_q[p] <= sync[p];
              cnt_q[p]  <= '0;
            end else begin
              cnt_q[p] <= cnt_q[p] + 1'b1;
            end
          end
        end
      end

      assign filt = filt_q;
    end else begin : g_bypass
      assign filt = sync;
    end
  endgenerate

  assign data_o   = filt;
  assign rise_evt = filt & ~filt_d & rise_en_i;
  assign fall_evt = ~filt & filt_d & fall_en_i;

  // A new edge outranks a clear landing on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_d       <= '0;
      irq_status_o <= '0;
    end else begin
      filt_d       <= filt;
      irq_status_o <= (irq_status_o & ~irq_clr_i) | rise_evt | fall_evt;
    end
  end

  assign irq_o = |irq_status_o;

endmodule
